// File: rtl/ram_window_reader.sv
// ram_window_reader: sweeps a 5x5 raster window over a row-major RAM image and hands each window downstream.
// Optional REQ timeout with sticky error is enabled by defining RAM_READER_TIMEOUT_EN.
module ram_window_reader #(
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 16,
  parameter int TIMEOUT = 255
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [ADDR_W-1:0]    base_addr,
  input  logic [ADDR_W-1:0]    img_width,
  input  logic [ADDR_W-1:0]    img_height,
  output logic                 busy,
  output logic                 done,
  output logic                 ram_enable,
  output logic                 ram_write,
  output logic [ADDR_W-1:0]    ram_address,
  output logic [ADDR_W-1:0]    ram_offset,
  input  logic                 ram_finish,
  input  logic [25*DATA_W-1:0] ram_data,
  output logic [25*DATA_W-1:0] win_data,
  output logic                 win_valid,
  input  logic                 win_ready,
  output logic [ADDR_W-1:0]    win_row,
  output logic [ADDR_W-1:0]    win_col,
  output logic                 error
);
  localparam int CW = $clog2(TIMEOUT + 1);
  typedef enum logic [1:0] {IDLE, REQ, HOLD, DONE} state_t;
  state_t state, state_n;
  logic [ADDR_W-1:0] w, h, row, col, row_base;
  logic [CW-1:0] cnt;
  logic take, xfer, last, expire;
  // cnt is zero in the first REQ cycle, where a stale ram_finish must be ignored
  assign take        = state == REQ && cnt != '0 && ram_finish;
  assign xfer        = state == HOLD && win_ready;
  assign last        = row == h - ADDR_W'(5) && col == w - ADDR_W'(5);
  assign busy        = state != IDLE;
  assign done        = state == DONE;
  assign ram_enable  = state == REQ;
  assign ram_write   = 1'b0;
  assign ram_address = row_base + col;
  assign ram_offset  = w;
  assign win_valid   = state == HOLD;
`ifdef RAM_READER_TIMEOUT_EN
  assign expire = state == REQ && !take && cnt == CW'(TIMEOUT - 1);
  always_ff @(posedge clk)
    if (rst) error <= 1'b0;
    else error <= state == IDLE && start ? 1'b0 : error | expire;
`else
  assign expire = 1'b0;
  assign error  = 1'b0;
`endif
  always_ff @(posedge clk) state <= rst ? IDLE : state_n;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = !start ? IDLE : (img_width < ADDR_W'(5) || img_height < ADDR_W'(5)) ? DONE : REQ;
      REQ:     state_n = take ? HOLD : expire ? DONE : REQ;
      HOLD:    state_n = !xfer ? HOLD : last ? DONE : REQ;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      w        <= '0;
      h        <= '0;
      row      <= '0;
      col      <= '0;
      row_base <= '0;
      cnt      <= '0;
      win_data <= '0;
      win_row  <= '0;
      win_col  <= '0;
    end else begin
      cnt <= state != REQ ? '0 : &cnt ? cnt : cnt + 1'b1;
      if (state == IDLE && start) begin
        w        <= img_width;
        h        <= img_height;
        row      <= '0;
        col      <= '0;
        row_base <= base_addr;
      end
      if (take) begin
        win_data <= ram_data;
        win_row  <= row;
        win_col  <= col;
      end
      if (xfer && !last) begin
        if (col < w - ADDR_W'(5)) col <= col + 1'b1;
        else begin
          col      <= '0;
          row      <= row + 1'b1;
          row_base <= row_base + w;
        end
      end
    end
  end
endmodule

// File: tb/tb_ram_window_reader.sv
// tb_ram_window_reader: randomized sweeps checked every cycle against a window-list model of the sweep.
module tb_ram_window_reader;
  localparam int DW = 16, AW = 16, TO = 20;
  logic clk = 0, rst = 1, start = 0;
  logic [AW-1:0] base_addr = '0, img_width = '0, img_height = '0;
  logic busy, done, ram_enable, ram_write, win_valid, error;
  logic [AW-1:0] ram_address, ram_offset, win_row, win_col;
  logic ram_finish = 0, win_ready = 0;
  logic [25*DW-1:0] ram_data, win_data;
  always #5 clk = ~clk;

  ram_window_reader #(.DATA_W(DW), .ADDR_W(AW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .img_width(img_width),
    .img_height(img_height), .busy(busy), .done(done), .ram_enable(ram_enable),
    .ram_write(ram_write), .ram_address(ram_address), .ram_offset(ram_offset),
    .ram_finish(ram_finish), .ram_data(ram_data), .win_data(win_data), .win_valid(win_valid),
    .win_ready(win_ready), .win_row(win_row), .win_col(win_col), .error(error));

  int checks = 0, failures = 0;
  int W = 0, H = 0, nwin = 0, fmode = 0, rmode = 0;
  logic [AW-1:0] base = '0;
  logic [DW-1:0] salt = '0;
  bit tmo = 0, chk_on = 0, active = 0, prev_en = 0, prev_wait = 0, exp_error = 0;
  int req_idx = 0, xfer_idx = 0, done_cnt = 0, start_cyc = -100, last_xfer_cyc = -100;
  int fall_cyc = -100, cyc = 0, lat = 2, en_cnt = 0, hold_cnt = 0;
  logic [AW-1:0] addr_log[$];
  logic [25*DW-1:0] first_win = '0;

  task automatic chk(string n, logic [63:0] a, logic [63:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", n, a, e, cyc);
    end
  endtask

  task automatic chk_win(string n, logic [25*DW-1:0] a, logic [25*DW-1:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s: got %h expected %h", n, a, e);
    end
  endtask

  // RAM contents: word at address a holds a ^ salt
  function automatic logic [25*DW-1:0] exp_win(logic [AW-1:0] a, logic [AW-1:0] w, logic [DW-1:0] s);
    logic [25*DW-1:0] v;
    logic [AW-1:0] x;
    v = '0;
    for (int r = 0; r < 5; r++)
      for (int c = 0; c < 5; c++) begin
        x = a + AW'(r) * w + AW'(c);
        v[(r*5+c)*DW +: DW] = DW'(x) ^ s;
      end
    return v;
  endfunction

  function automatic logic [AW-1:0] waddr(int i);
    int q;
    q = W - 4;
    return base + AW'((i / q) * W) + AW'(i % q);
  endfunction

  assign ram_data = exp_win(ram_address, ram_offset, salt);

  always @(negedge clk) begin
    if (chk_on) begin
      if (ram_enable) begin
        if (en_cnt == 0) lat = $urandom_range(1, 4);
        en_cnt++;
      end
      ram_finish = fmode == 1 ? 1'b1 : (fmode == 0 && ram_enable && en_cnt >= lat);
      win_ready = rmode == 0 ? 1'b1 : rmode == 1 ? ($urandom % 2 == 1) : !(xfer_idx == 1 && hold_cnt < 10);
      if (cyc == start_cyc + 1) active = 1;
      chk("busy", busy, active);
      chk("ram_write", ram_write, 0);
      chk("enable_vs_valid", ram_enable & win_valid, 0);
      if (ram_enable && !prev_en) begin
        chk("req_after_xfer", req_idx, xfer_idx);
        if (req_idx == 0) chk("first_req_lat", cyc - start_cyc, 1);
        chk("req_in_range", req_idx < nwin, 1);
        if (req_idx < nwin) chk("req_addr", ram_address, waddr(req_idx));
        chk("req_offset", ram_offset, W);
        addr_log.push_back(ram_address);
        req_idx++;
      end
      if (!ram_enable && prev_en) begin
        chk("req_len", en_cnt, tmo ? TO : (fmode == 1 || lat < 2) ? 2 : lat);
        if (tmo) exp_error = 1;
        fall_cyc = cyc;
        en_cnt = 0;
      end
      chk("error", error, exp_error);
      if (prev_wait) chk("hold_valid", win_valid, 1);
      if (win_valid) begin
        chk("win_in_range", xfer_idx < nwin, 1);
        if (xfer_idx < nwin) begin
          chk("win_row", win_row, xfer_idx / (W - 4));
          chk("win_col", win_col, xfer_idx % (W - 4));
          chk_win("win_data", win_data, exp_win(waddr(xfer_idx), AW'(W), salt));
          if (xfer_idx == 0) first_win = win_data;
        end
      end
      if (done) begin
        chk("done_cyc", cyc, nwin == 0 ? start_cyc + 1 : tmo ? fall_cyc : last_xfer_cyc + 1);
        chk("done_xfers", xfer_idx, tmo ? 0 : nwin);
        done_cnt++;
        active = 0;
      end
      if (win_valid && win_ready) begin
        xfer_idx++;
        last_xfer_cyc = cyc;
        hold_cnt = 0;
      end else if (win_valid) hold_cnt++;
      prev_wait = win_valid && !win_ready;
      prev_en = ram_enable;
    end
    cyc++;
  end

  task automatic tick;
    @(negedge clk);
    #1;
  endtask

  task automatic chk_reset;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_enable", ram_enable, 0);
    chk("rst_write", ram_write, 0);
    chk("rst_address", ram_address, 0);
    chk("rst_offset", ram_offset, 0);
    chk("rst_valid", win_valid, 0);
    chk_win("rst_win_data", win_data, '0);
    chk("rst_row", win_row, 0);
    chk("rst_col", win_col, 0);
    chk("rst_error", error, 0);
  endtask

  task automatic begin_sweep(int b, int w, int h, int fm, int rm, logic [DW-1:0] s, bit t);
    tick;
    base = AW'(b); W = w; H = h; fmode = fm; rmode = rm; salt = s; tmo = t;
    nwin = (w >= 5 && h >= 5) ? (w - 4) * (h - 4) : 0;
    req_idx = 0; xfer_idx = 0; done_cnt = 0; hold_cnt = 0;
    addr_log.delete();
    base_addr = AW'(b); img_width = AW'(w); img_height = AW'(h);
    start = 1;
    start_cyc = cyc - 1;
    exp_error = 0;
  endtask

  task automatic end_sweep;
    for (int i = 0; i < 4000 && done_cnt == 0; i++) begin
      tick;
      start = busy && rmode == 1 && $urandom % 3 == 0;
      if (start) begin
        base_addr = AW'($urandom); img_width = AW'($urandom); img_height = AW'($urandom);
      end
    end
    start = 0;
    chk("done_seen", done_cnt > 0, 1);
    repeat (3) tick;
    chk("done_once", done_cnt, 1);
    chk("xfer_total", xfer_idx, tmo ? 0 : nwin);
    chk("req_total", req_idx, tmo ? 1 : nwin);
  endtask

  task automatic sweep(int b, int w, int h, int fm, int rm, logic [DW-1:0] s, bit t);
    begin_sweep(b, w, h, fm, rm, s, t);
    end_sweep;
  endtask

  initial begin
    int found;
    logic [AW-1:0] exp_addrs[6];
    exp_addrs = '{100, 101, 102, 107, 108, 109};
    repeat (3) tick;
    chk_reset;
    rst = 0;
    chk_on = 1;
    sweep(100, 7, 6, 0, 0, '0, 0);
    chk("t1_windows", addr_log.size(), 6);
    for (int i = 0; i < 6 && i < addr_log.size(); i++) chk("t1_addr_seq", addr_log[i], exp_addrs[i]);
    chk("t1_w00", first_win[0 +: DW], 100);
    chk("t1_w23", first_win[13*DW +: DW], 117);
    chk("t1_w44", first_win[24*DW +: DW], 132);
    sweep(100, 7, 6, 0, 2, '0, 0);
    sweep(100, 7, 6, 1, 0, 16'h5a5a, 0);
    sweep(0, 4, 10, 0, 0, '0, 0);
    begin_sweep(100, 7, 6, 0, 0, 16'h0f0f, 0);
    found = 0;
    for (int i = 0; i < 200 && found == 0; i++) begin
      tick;
      start = 0;
      if (req_idx == 3 && ram_enable) found = 1;
    end
    chk("rst_reached_req3", found, 1);
    rst = 1;
    chk_on = 0;
    tick;
    chk_reset;
    rst = 0;
    active = 0; prev_en = 0; prev_wait = 0; en_cnt = 0; exp_error = 0;
    chk_on = 1;
    sweep(100, 7, 6, 0, 0, '0, 0);
    chk("restart_addr0", addr_log.size() > 0 ? addr_log[0] : 16'hffff, 100);
    for (int k = 0; k < 6; k++)
      sweep(int'($urandom % 65536), int'($urandom_range(5, 9)), int'($urandom_range(5, 8)), 0, 1, DW'($urandom), 0);
    sweep(int'($urandom % 65536), 10, 3, 0, 1, '0, 0);
`ifdef RAM_READER_TIMEOUT_EN
    sweep(100, 7, 6, 2, 0, '0, 1);
    chk("tmo_error_set", error, 1);
    sweep(100, 7, 6, 0, 0, '0, 0);
    chk("tmo_error_cleared", error, 0);
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
